// File: rtl/rf_wb_queue.sv
// Register-file write-port merger: source A (never stalls) wins the write slot,
// source B results wait in a small FIFO with WAW kill and a pending-query port.
module rf_wb_queue #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic                   a_valid,
    input  logic [4:0]             a_addr,
    input  logic [31:0]            a_data,
    input  logic                   b_valid,
    output logic                   b_ready,
    input  logic [4:0]             b_addr,
    input  logic [31:0]            b_data,
    input  logic [4:0]             q_addr,
    output logic                   q_pending,
    output logic                   stall_req,
    output logic                   rf_w,
    output logic [4:0]             rf_addr,
    output logic [31:0]            rf_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    logic [4:0]       addr_mem [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [DEPTH-1:0] live_mem;
    logic [DEPTH-1:0] live_next;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [SW-1:0]    starve;

    logic full;
    logic empty;
    logic a_win;
    logic push;
    logic pop;

    // Handshake: B transfers on an edge where b_valid & b_ready are both high;
    // A has no ready and a non-zero A address always takes the write slot.
    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign b_ready = ena & ~full;
    assign a_win   = a_valid & (a_addr != 5'd0);
    assign push    = b_valid & b_ready;
    assign pop     = ena & ~a_win & ~empty;

    assign stall_req = full | (starve >= STARVE_TOP);

    // Popped slots are cleared so that a set live bit always means "occupied".
    always_comb begin
        live_next = live_mem;
        if (ena) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (a_win && addr_mem[i] == a_addr) begin
                    live_next[i] = 1'b0;
                end
            end
            if (pop) begin
                live_next[rd_ptr] = 1'b0;
            end
            // A same-cycle push is younger than the A write, so it survives the kill.
            if (push) begin
                live_next[wr_ptr] = (b_addr != 5'd0);
            end
        end
    end

    always_comb begin
        q_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_mem[i] && addr_mem[i] == q_addr) begin
                q_pending = 1'b1;
            end
        end
        if (q_addr == 5'd0) begin
            q_pending = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= b_addr;
            data_mem[wr_ptr] <= b_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            live_mem <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            starve   <= '0;
        end else if (ena) begin
            live_mem <= live_next;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (a_win && !empty) begin
                if (starve != STARVE_TOP) begin
                    starve <= starve + 1'b1;
                end
            end else begin
                starve <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_w    <= 1'b0;
            rf_addr <= 5'd0;
            rf_data <= 32'd0;
        end else if (!ena) begin
            rf_w <= 1'b0;
        end else if (a_win) begin
            rf_w    <= 1'b1;
            rf_addr <= a_addr;
            rf_data <= a_data;
        end else if (pop) begin
            // A dead head still leaves the FIFO but never reaches the register file.
            rf_w    <= live_mem[rd_ptr] && (addr_mem[rd_ptr] != 5'd0);
            rf_addr <= addr_mem[rd_ptr];
            rf_data <= data_mem[rd_ptr];
        end else begin
            rf_w <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_wb_queue.sv
// Directed bench for rf_wb_queue: each step drives inputs, advances one edge and
// compares outputs against hand-computed values.
module tb_rf_wb_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic [4:0]  q_addr;
    logic        q_pending;
    logic        stall_req;
    logic        rf_w;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [2:0]  count;

    int passed = 0;
    int total  = 0;

    rf_wb_queue #(.DEPTH(4), .STARVE_MAX(8)) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .q_addr(q_addr), .q_pending(q_pending), .stall_req(stall_req),
        .rf_w(rf_w), .rf_addr(rf_addr), .rf_data(rf_data), .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic drive_a(input logic v, input logic [4:0] ad, input logic [31:0] d);
        a_valid = v;
        a_addr  = ad;
        a_data  = d;
    endtask

    task automatic drive_b(input logic v, input logic [4:0] ad, input logic [31:0] d);
        b_valid = v;
        b_addr  = ad;
        b_data  = d;
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; q_addr = 5'd0;
        drive_a(1'b0, 5'd0, 32'd0);
        drive_b(1'b0, 5'd0, 32'd0);
        tick(); tick();
        rst = 1'b0;
        settle();
        chk("rst_rf_w", rf_w, 0);
        chk("rst_rf_addr", rf_addr, 0);
        chk("rst_rf_data", rf_data, 0);
        chk("rst_count", count, 0);
        chk("rst_stall", stall_req, 0);
        chk("rst_b_ready", b_ready, 1);

        // 1: single A write
        drive_a(1'b1, 5'd5, 32'h1234);
        tick();
        drive_a(1'b0, 5'd0, 32'd0);
        chk("t1_rf_w", rf_w, 1);
        chk("t1_rf_addr", rf_addr, 5);
        chk("t1_rf_data", rf_data, 32'h1234);
        tick();
        chk("t1_idle_rf_w", rf_w, 0);

        // 2: two B pushes while A occupies the port, then drain with A idle
        drive_a(1'b1, 5'd10, 32'h10);
        drive_b(1'b1, 5'd3, 32'hAA);
        tick();
        chk("t2_count1", count, 1);
        chk("t2_a_addr", rf_addr, 10);
        drive_a(1'b1, 5'd10, 32'h11);
        drive_b(1'b1, 5'd4, 32'hBB);
        tick();
        chk("t2_count2", count, 2);
        drive_a(1'b0, 5'd0, 32'd0);
        drive_b(1'b0, 5'd0, 32'd0);
        q_addr = 5'd4;
        settle();
        chk("t2_pend_r4_a", q_pending, 1);
        tick();
        chk("t2_pop1_w", rf_w, 1);
        chk("t2_pop1_addr", rf_addr, 3);
        chk("t2_pop1_data", rf_data, 32'hAA);
        chk("t2_count_1", count, 1);
        chk("t2_pend_r4_b", q_pending, 1);
        tick();
        chk("t2_pop2_w", rf_w, 1);
        chk("t2_pop2_addr", rf_addr, 4);
        chk("t2_pop2_data", rf_data, 32'hBB);
        chk("t2_count_0", count, 0);
        chk("t2_pend_r4_c", q_pending, 0);
        tick();
        chk("t2_idle_w", rf_w, 0);

        // 3: fill with A busy, full refuses a push, then drain
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, 5'd9, 32'h900 + i);
            drive_b(1'b1, 5'(11 + i), 32'h100 + i);
            tick();
        end
        drive_a(1'b0, 5'd0, 32'd0);
        drive_b(1'b1, 5'd15, 32'h1FF);
        settle();
        chk("t3_count_full", count, 4);
        chk("t3_b_ready", b_ready, 0);
        chk("t3_stall", stall_req, 1);
        tick();
        drive_b(1'b0, 5'd0, 32'd0);
        chk("t3_count_3", count, 3);
        chk("t3_pop_addr", rf_addr, 11);
        chk("t3_pop_data", rf_data, 32'h100);
        chk("t3_stall_off", stall_req, 0);
        tick();
        chk("t3_pop12", rf_addr, 12);
        tick();
        chk("t3_pop13", rf_addr, 13);
        tick();
        chk("t3_pop14_addr", rf_addr, 14);
        chk("t3_pop14_data", rf_data, 32'h103);
        chk("t3_count_0", count, 0);
        tick();
        chk("t3_no_r15", rf_w, 0);

        // 4: WAW kill of an older B entry
        drive_a(1'b1, 5'd20, 32'h20);
        drive_b(1'b1, 5'd7, 32'h1);
        tick();
        chk("t4_count1", count, 1);
        drive_a(1'b1, 5'd7, 32'h2);
        drive_b(1'b0, 5'd0, 32'd0);
        q_addr = 5'd7;
        settle();
        chk("t4_pend_before", q_pending, 1);
        tick();
        drive_a(1'b0, 5'd0, 32'd0);
        chk("t4_a_addr", rf_addr, 7);
        chk("t4_a_data", rf_data, 32'h2);
        chk("t4_pend_killed", q_pending, 0);
        chk("t4_count_still1", count, 1);
        tick();
        chk("t4_dead_pop_w", rf_w, 0);
        chk("t4_count0", count, 0);

        // 4b: same-cycle push to the A address is younger and survives
        drive_a(1'b1, 5'd8, 32'h3);
        drive_b(1'b1, 5'd8, 32'h4);
        q_addr = 5'd8;
        tick();
        drive_a(1'b0, 5'd0, 32'd0);
        drive_b(1'b0, 5'd0, 32'd0);
        chk("t4b_a_data", rf_data, 32'h3);
        chk("t4b_pend", q_pending, 1);
        tick();
        chk("t4b_b_w", rf_w, 1);
        chk("t4b_b_addr", rf_addr, 8);
        chk("t4b_b_data", rf_data, 32'h4);

        // 5: starvation raises stall_req after STARVE_MAX A cycles
        drive_a(1'b1, 5'd21, 32'h0);
        drive_b(1'b1, 5'd6, 32'h66);
        tick();
        drive_b(1'b0, 5'd0, 32'd0);
        for (int i = 1; i <= 7; i++) begin
            drive_a(1'b1, 5'd21, 32'(i));
            tick();
        end
        chk("t5_stall_7", stall_req, 0);
        tick();
        chk("t5_stall_8", stall_req, 1);
        chk("t5_count", count, 1);
        drive_a(1'b0, 5'd0, 32'd0);
        tick();
        chk("t5_drain_addr", rf_addr, 6);
        chk("t5_drain_data", rf_data, 32'h66);
        chk("t5_stall_clear", stall_req, 0);

        // ena low freezes the queue and suppresses writes
        ena = 1'b0;
        drive_a(1'b1, 5'd22, 32'h22);
        drive_b(1'b1, 5'd2, 32'h2);
        settle();
        chk("en_b_ready", b_ready, 0);
        tick();
        chk("en_rf_w", rf_w, 0);
        chk("en_count", count, 0);
        ena = 1'b1;
        drive_a(1'b0, 5'd0, 32'd0);
        drive_b(1'b0, 5'd0, 32'd0);

        // 6: register 0 writes never reach the file
        drive_a(1'b1, 5'd0, 32'hDEAD);
        drive_b(1'b1, 5'd0, 32'h5);
        tick();
        chk("t6_r0_w", rf_w, 0);
        chk("t6_r0_count", count, 1);
        drive_b(1'b0, 5'd0, 32'd0);
        tick();
        chk("t6_r0_pop_w", rf_w, 0);
        chk("t6_r0_count0", count, 0);
        drive_a(1'b0, 5'd0, 32'd0);

        // 6b: reset in the middle of a drain
        drive_a(1'b1, 5'd9, 32'h9);
        drive_b(1'b1, 5'd1, 32'h11);
        tick();
        drive_b(1'b1, 5'd2, 32'h22);
        tick();
        chk("t6b_count2", count, 2);
        drive_a(1'b0, 5'd0, 32'd0);
        drive_b(1'b0, 5'd0, 32'd0);
        tick();
        chk("t6b_pop_addr", rf_addr, 1);
        chk("t6b_count1", count, 1);
        rst = 1'b1;
        q_addr = 5'd2;
        tick();
        chk("t6b_rst_count", count, 0);
        chk("t6b_rst_w", rf_w, 0);
        chk("t6b_rst_addr", rf_addr, 0);
        chk("t6b_rst_pend", q_pending, 0);
        rst = 1'b0;
        tick();
        chk("t6b_after_w", rf_w, 0);
        chk("t6b_after_count", count, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
